// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit period, state numbering, byte width.
package uart_pkg;

    // Default clock cycles per serial bit; uart_tx uses the same value.
    localparam int CLKS_PER_BIT_DEF = 16;

    // Byte width carried on the serial line.
    localparam int UART_DATA_W = 8;

    // State numbering shared with uart_tx so benches can probe state
    // values identically in both blocks.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_START = START,
        ST_DATA  = DATA,
        ST_STOP  = STOP
    } uart_state_e;

    // Registered receiver outputs.
    typedef struct packed {
        logic [UART_DATA_W-1:0] data;
        logic                   valid;
        logic                   frame_err;
    } rx_out_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rx line into the clk domain and flags falling edges.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic s1;
    logic rx_d;

    // Two-flop synchronizer plus one delay flop; reset to the idle (high) level
    // so a quiet line never looks like an edge coming out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            s1   <= rx;
            rx_s <= s1;
            rx_d <= rx_s;
        end
    end

    // High for exactly one cycle when the synchronized line goes 1 -> 0.
    // A line held low produces no edge, so breaks never re-trigger.
    assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification, mid-bit sampling, stop check.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] data,
    output logic                   valid,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic rx_s;
    logic fall;

    uart_state_e            state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [2:0]             idx, idx_n;
    logic [UART_DATA_W-1:0] sh, sh_n;
    rx_out_t                out_q, out_n;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    // State, counters, shift register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            out_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
            out_q <= out_n;
        end
    end

    // Next-state and datapath updates; pulses default low so they last one cycle.
    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        idx_n           = idx;
        sh_n            = sh;
        out_n           = out_q;
        out_n.valid     = 1'b0;
        out_n.frame_err = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (fall) state_n = ST_START;
            end

            // Re-check the line half a bit in; a high sample was a glitch.
            ST_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // From mid-start, one full bit period lands on mid-data-bit.
            ST_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    sh_n  = {rx_s, sh[UART_DATA_W-1:1]};
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) state_n = ST_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // Leave at mid-stop so a start bit right after it is still caught.
            ST_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                    if (rx_s) begin
                        out_n.data  = sh;
                        out_n.valid = 1'b1;
                    end else begin
                        out_n.frame_err = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    assign data      = out_q.data;
    assign valid     = out_q.valid;
    assign frame_err = out_q.frame_err;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a byte scoreboard fed by the serial driver.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_rx     = 0;
    int          n_ferr   = 0;
    int          last_vcyc = 0;
    logic [7:0]  exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every valid pulse.
    initial begin
        logic prev_pulse;
        logic [7:0] e;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid || frame_err) begin
                    chk("pulse_exclusive", {31'd0, valid & frame_err}, 32'd0);
                    chk("pulse_one_cycle", {31'd0, prev_pulse}, 32'd0);
                end
                if (valid) begin
                    n_rx++;
                    last_vcyc = cyc;
                    chk("unexpected_valid", exp_q.size(), 32'd0 + (exp_q.size() > 0 ? exp_q.size() : 1));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rx_data", {24'd0, data}, {24'd0, e});
                    end
                end
                if (frame_err) n_ferr++;
                prev_pulse = valid | frame_err;
            end else begin
                prev_pulse = 1'b0;
            end
        end
    end

    // Drives one 8N1 frame; optionally pulses rst for one cycle mid data bit.
    task automatic send(input logic [7:0] b, input logic stopb, input int rst_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == rst_bit) begin
                repeat (HALF) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_mid_data", {24'd0, data}, 32'd0);
                chk("rst_mid_busy", {31'd0, busy}, 32'd0);
                chk("rst_mid_valid", {31'd0, valid}, 32'd0);
                repeat (CPB - HALF - 1) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        rx = stopb;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t0;
        rx  = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_data", {24'd0, data}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle(4);

        // Single frame 0x41 and its latency from the first low level.
        exp_q.push_back(8'h41);
        t0 = cyc;
        send(8'h41, 1'b1, -1);
        idle(2 * CPB);
        chk("single_count", n_rx, 1);
        // valid is high after edge 2+HALF+9*CPB, edge 0 being the next posedge.
        chk("single_latency", last_vcyc - t0, 2 + HALF + 9 * CPB + 1);
        chk("single_no_ferr", n_ferr, 0);

        // Back-to-back frames with only the stop bit between them.
        exp_q.push_back(8'h41);
        send(8'h41, 1'b1, -1);
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, -1);
        idle(2 * CPB);
        chk("b2b_count", n_rx, 3);
        chk("b2b_data", {24'd0, data}, 32'h0000_00A5);

        // Three-cycle glitch: start qualified, then rejected at mid-start.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
        repeat (HALF - 2) @(negedge clk);
        chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
        idle(2 * CPB);
        chk("glitch_count", n_rx, 3);
        chk("glitch_data", {24'd0, data}, 32'h0000_00A5);

        // Framing error, long break, then recovery.
        exp_q.push_back(8'h41);
        send(8'h41, 1'b1, -1);
        send(8'h3C, 1'b0, -1);
        rx = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        chk("ferr_count", n_ferr, 1);
        chk("ferr_data_kept", {24'd0, data}, 32'h0000_0041);
        chk("break_no_start", {31'd0, busy}, 32'd0);
        idle(2 * CPB);
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1, -1);
        idle(2 * CPB);
        chk("recover_count", n_rx, 5);

        // Reset during data bit 4 of an abandoned frame.
        send(8'hF0, 1'b1, 4);
        idle(2 * CPB);
        chk("rst_no_pulse", n_rx, 5);
        chk("rst_data_cleared", {24'd0, data}, 32'd0);
        exp_q.push_back(8'hC3);
        send(8'hC3, 1'b1, -1);
        idle(2 * CPB);
        chk("after_rst_count", n_rx, 6);
        chk("after_rst_data", {24'd0, data}, 32'h0000_00C3);

        // All-ones and all-zeros payloads.
        exp_q.push_back(8'hFF);
        send(8'hFF, 1'b1, -1);
        exp_q.push_back(8'h00);
        send(8'h00, 1'b1, -1);
        idle(2 * CPB);
        chk("extremes_count", n_rx, 8);
        chk("final_ferr", n_ferr, 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver and the downstream partner of `uart_tx`. It samples the asynchronous serial line `rx`, detects a start bit, and samples 8 data bits LSB-first at mid-bit. It checks the stop bit and presents each byte with a one-cycle `valid` strobe. In the top level it consumes `uart_tx.tx` in loopback and in the board build; it also drives a host-side byte consumer.

## Interface
- `CLKS_PER_BIT`, default 16 — clock cycles per serial bit; even, ≥ 4; must match `uart_tx`.
- `HALF_BIT`, default `CLKS_PER_BIT/2` — derived local constant, not overridable.
- `clk`  in  1  — single system clock; all logic on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `rx`  in  1  — asynchronous serial input; idle high.
- `data`  out  8  — last correctly framed byte; holds until the next good frame.
- `valid`  out  1  — one-cycle pulse; `data` is new in the same cycle.
- `frame_err`  out  1  — one-cycle pulse; stop bit sampled low; `data` unchanged.
- `busy`  out  1  — high whenever state ≠ IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`) plus one delay flop (`rx_d`).
- Falling edge is `rx_d & ~rx_s`. A line held low produces no edge, so there is no re-trigger after an error or break.
- Bit counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide; bit index `idx` is 3 bits; the shift register is 8 bits.
- **IDLE:** `cnt` = 0. On a falling edge → START.
- **START:** `cnt` increments each cycle. At `cnt == HALF_BIT-1`, sample `rx_s`.
  - Sample 0 → DATA, with `cnt` = 0 and `idx` = 0.
  - Sample 1 (glitch) → IDLE, with no output pulse.
- **DATA:** at `cnt == CLKS_PER_BIT-1`, the following happen in that cycle:
  - shift `rx_s` into the MSB (right shift, LSB-first);
  - clear `cnt`;
  - advance `idx`. After `idx == 7` is sampled → STOP.
- **STOP:** at `cnt == CLKS_PER_BIT-1`, sample `rx_s`, then → IDLE.
  - Sample 1: load `data` from the shift register; pulse `valid`.
  - Sample 0: pulse `frame_err`.
  - Because the return to IDLE happens at mid-stop-bit, a start bit arriving immediately after the stop bit is caught.
- `valid` and `frame_err` are never high together and never high for two consecutive cycles.
- **Reset:** state IDLE; `cnt`, `idx`, shift register = 0; `data` = 8'h00; `valid`, `frame_err`, `busy` = 0. Synchronizer and delay flops reset to 1 (idle line).
- Reset mid-frame abandons the frame with no pulse. After reset, a new frame requires a fresh falling edge.

## Timing
- Edge 0 is the first `clk` edge that samples `rx` low into sync1.
  - START is entered at edge 2.
  - The start bit is verified at edge `2+HALF_BIT`.
  - Data bit i is sampled at edge `2+HALF_BIT+(i+1)·CLKS_PER_BIT`.
  - The stop bit is sampled at edge `2+HALF_BIT+9·CLKS_PER_BIT`.
- `valid`/`frame_err` are registered and high in the cycle after the stop-sample edge. With default parameters, `valid` is high after edge 154.
- `busy` rises after edge 2 and falls together with the `valid`/`frame_err` pulse.
- There is no backpressure. The consumer must capture `data` on `valid`. `data` is stable until the next `valid`.
- Tolerated baud mismatch: ±(HALF_BIT−1)/(9.5·CLKS_PER_BIT) cumulative. Mismatch is not checked.

## Structure
- Shared package `uart_pkg` contains:
  - the default `CLKS_PER_BIT`, also used by `uart_tx`;
  - the state encoding as localparams `IDLE=0, START=1, DATA=2, STOP=3`, the same numbering as `uart_tx`, so benches can probe `state == 2` in both;
  - the `UART_DATA_W = 8` constant.
- One sub-module, `uart_rx_sync`:
  - contains the 2-flop synchronizer, the delay flop and the falling-edge detect;
  - has ports `clk`, `rst`, `rx`, `rx_s`, `fall`;
  - reset value is 1.
- FSM, counters and output registers live in `uart_rx`.

## Test plan
- **Loopback 0x41:** instantiate `uart_tx` → `uart_rx`; pulse `start` with data 8'h41 → one `valid` pulse, `data` = 8'h41, `frame_err` never high. `valid` occurs exactly `2+HALF_BIT+9·CLKS_PER_BIT` edges after `tx` first falls.
- **Back-to-back:** send 8'h41 then 8'hA5 with no idle gap beyond one stop bit → two `valid` pulses, `data` 8'h41 then 8'hA5; bytes-received counter = 2.
- **Start glitch:** drive `rx` low for 3 cycles, then high → `busy` pulses, returns to IDLE by edge `2+HALF_BIT`, no `valid`, `data` unchanged.
- **Framing error:** hand-drive 8'h3C with the stop bit low → `frame_err` pulses once and `data` keeps the previous 8'h41. Hold `rx` low for 40 bit-times → no new START. Release high, then send 8'h55 → `valid` with 8'h55.
- **Reset mid-frame:** assert `rst` for one cycle during data bit 4 → outputs return to reset values and no pulse occurs. The next full frame 8'hC3 → `valid` with 8'hC3.
- **All-ones / all-zeros:** frames 8'hFF and 8'h00 → received exactly, one `valid` each.
